// File: rtl/tb_tcdm_banked_memory.sv
// Multi-port, word-interleaved banked TCDM model with round-robin arbitration,
// fixed response latency and LFSR stalls. Optional: TB_TCDM_CONFLICT_CNT_EN adds cnt_conflict_o.
module tb_tcdm_banked_memory #(
  parameter int unsigned NP           = 5,
  parameter int unsigned NB           = 4,
  parameter int unsigned MEMORY_SIZE  = 262144,
  parameter logic [31:0] BASE_ADDR    = 32'h0,
  parameter int unsigned LATENCY      = 1,
  parameter int unsigned STALL_THRESH = 102,
  parameter logic [31:0] LFSR_SEED    = 32'hACE1_1234
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic             randomize_i,
  input  logic             stallable_i,
  input  logic             clear_i,
  input  logic [NP-1:0]    tcdm_req_i,
  output logic [NP-1:0]    tcdm_gnt_o,
  input  logic [NP*32-1:0] tcdm_add_i,
  input  logic [NP-1:0]    tcdm_wen_i,
  input  logic [NP*4-1:0]  tcdm_be_i,
  input  logic [NP*32-1:0] tcdm_data_i,
  output logic [NP*32-1:0] tcdm_r_data_o,
  output logic [NP-1:0]    tcdm_r_valid_o,
  output logic [NP*32-1:0] cnt_rd_o,
  output logic [NP*32-1:0] cnt_wr_o
`ifdef TB_TCDM_CONFLICT_CNT_EN
  ,
  output logic [NP*32-1:0] cnt_conflict_o
`endif
);

  localparam int unsigned NWORDS = MEMORY_SIZE / 4;
  localparam int unsigned AW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int unsigned PW     = (NP > 1) ? $clog2(NP) : 1;

  // Word w lives at memory[w]; preloaded externally, never reset.
  logic [31:0]      memory [NWORDS];
  logic [31:0]      lfsr_q;
  logic [PW-1:0]    rr_ptr_q [NB];
  logic [PW-1:0]    win [NB];
  logic [NB-1:0]    bank_gnt;
  logic [31:0]      word_idx [NP];
  logic [31:0]      bank_of [NP];
  logic [NP-1:0]    in_range;
  logic [NP-1:0]    eligible;
  logic [NP-1:0]    gnt;
  logic [NP*32-1:0] resp_d;
  logic [NP-1:0]    pipe_v [LATENCY];
  logic [NP*32-1:0] pipe_d [LATENCY];
  logic [NP*32-1:0] hold_q;
  logic [31:0]      cnt_rd_q [NP];
  logic [31:0]      cnt_wr_q [NP];

  function automatic logic [31:0] rotl(input logic [31:0] v, input int unsigned s);
    return (v << s) | (v >> (32 - s));
  endfunction

  always_comb begin
    logic [31:0] rot;
    logic        stalled;
    rot     = '0;
    stalled = 1'b0;
    for (int p = 0; p < int'(NP); p++) begin
      word_idx[p] = (tcdm_add_i[p*32 +: 32] - BASE_ADDR) >> 2;
      bank_of[p]  = word_idx[p] % NB;
      in_range[p] = (tcdm_add_i[p*32 +: 32] >= BASE_ADDR) && (word_idx[p] < 32'(NWORDS));
      rot         = rotl(lfsr_q, (3 * p) % 32);
      stalled     = randomize_i && stallable_i && ({22'b0, rot[9:0]} < 32'(STALL_THRESH));
      eligible[p] = rst_ni && tcdm_req_i[p] && enable_i && !stalled;
      resp_d[p*32 +: 32] = !tcdm_wen_i[p] ? 32'h0 :
                           in_range[p] ? memory[word_idx[p][AW-1:0]] : 32'hDEAD_BEEF;
    end
  end

  // Per bank: first eligible port at or after the pointer, wrapping.
  always_comb begin
    int idx;
    idx      = 0;
    gnt      = '0;
    bank_gnt = '0;
    for (int b = 0; b < int'(NB); b++) begin
      win[b] = '0;
      for (int k = 0; k < int'(NP); k++) begin
        idx = int'(rr_ptr_q[b]) + k;
        if (idx >= int'(NP)) idx = idx - int'(NP);
        if (!bank_gnt[b] && eligible[idx] && (bank_of[idx] == 32'(b))) begin
          gnt[idx]    = 1'b1;
          bank_gnt[b] = 1'b1;
          win[b]      = PW'(idx);
        end
      end
    end
  end

  assign tcdm_gnt_o     = gnt;
  assign tcdm_r_valid_o = pipe_v[LATENCY-1];

  always_comb begin
    for (int p = 0; p < int'(NP); p++) begin
      tcdm_r_data_o[p*32 +: 32] = pipe_v[LATENCY-1][p] ? pipe_d[LATENCY-1][p*32 +: 32]
                                                       : hold_q[p*32 +: 32];
      cnt_rd_o[p*32 +: 32] = cnt_rd_q[p];
      cnt_wr_o[p*32 +: 32] = cnt_wr_q[p];
    end
  end

  always_ff @(posedge clk_i) begin
    for (int p = 0; p < int'(NP); p++) begin
      for (int j = 0; j < 4; j++) begin
        if (gnt[p] && !tcdm_wen_i[p] && in_range[p] && tcdm_be_i[p*4+j])
          memory[word_idx[p][AW-1:0]][j*8 +: 8] <= tcdm_data_i[p*32 + j*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= LFSR_SEED;
      hold_q <= '0;
      for (int b = 0; b < int'(NB); b++) rr_ptr_q[b] <= '0;
      for (int i = 0; i < int'(LATENCY); i++) begin
        pipe_v[i] <= '0;
        pipe_d[i] <= '0;
      end
      for (int p = 0; p < int'(NP); p++) begin
        cnt_rd_q[p] <= '0;
        cnt_wr_q[p] <= '0;
      end
    end else begin
      lfsr_q <= lfsr_q[0] ? ((lfsr_q >> 1) ^ 32'h8020_0003) : (lfsr_q >> 1);
      for (int b = 0; b < int'(NB); b++) begin
        if (bank_gnt[b]) rr_ptr_q[b] <= (32'(win[b]) == NP - 1) ? '0 : win[b] + 1'b1;
      end
      pipe_v[0] <= gnt;
      pipe_d[0] <= resp_d;
      for (int i = 1; i < int'(LATENCY); i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
      for (int p = 0; p < int'(NP); p++) begin
        if (pipe_v[LATENCY-1][p]) hold_q[p*32 +: 32] <= pipe_d[LATENCY-1][p*32 +: 32];
        if (clear_i) begin
          cnt_rd_q[p] <= '0;
          cnt_wr_q[p] <= '0;
        end else if (gnt[p]) begin
          if (tcdm_wen_i[p] && cnt_rd_q[p] != 32'hFFFF_FFFF) cnt_rd_q[p] <= cnt_rd_q[p] + 1;
          if (!tcdm_wen_i[p] && cnt_wr_q[p] != 32'hFFFF_FFFF) cnt_wr_q[p] <= cnt_wr_q[p] + 1;
        end
      end
    end
  end

`ifdef TB_TCDM_CONFLICT_CNT_EN
  // Counts cycles a port was eligible but lost its bank; stalled cycles are not eligible.
  logic [31:0] cnt_cf_q [NP];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int p = 0; p < int'(NP); p++) cnt_cf_q[p] <= '0;
    end else begin
      for (int p = 0; p < int'(NP); p++) begin
        if (clear_i) cnt_cf_q[p] <= '0;
        else if (eligible[p] && !gnt[p] && cnt_cf_q[p] != 32'hFFFF_FFFF)
          cnt_cf_q[p] <= cnt_cf_q[p] + 1;
      end
    end
  end

  always_comb begin
    for (int p = 0; p < int'(NP); p++) cnt_conflict_o[p*32 +: 32] = cnt_cf_q[p];
  end
`endif

endmodule

// File: tb/tb_tb_tcdm_banked_memory.sv
// Directed bench for tb_tcdm_banked_memory: three instances share stimulus
// (LATENCY=1, LATENCY=3, LATENCY=2 with STALL_THRESH=1023).
module tb_tb_tcdm_banked_memory;
  localparam int NP = 5;
  localparam int MS = 4096;

  logic clk = 1'b0;
  logic rst_n, enable, randomize, stallable, clear;
  logic [NP-1:0]    req, wen;
  logic [NP*32-1:0] add, wdata;
  logic [NP*4-1:0]  be;

  logic [NP-1:0]    gnt_a, rv_a, gnt_b, rv_b, gnt_c, rv_c;
  logic [NP*32-1:0] rd_a, crd_a, cwr_a, rd_b, crd_b, cwr_b, rd_c, crd_c, cwr_c;
`ifdef TB_TCDM_CONFLICT_CNT_EN
  logic [NP*32-1:0] ccf_a, ccf_b, ccf_c;
`endif

  always #5 clk = ~clk;

  tb_tcdm_banked_memory #(.NP(NP), .MEMORY_SIZE(MS), .LATENCY(1)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .randomize_i(randomize),
    .stallable_i(stallable), .clear_i(clear), .tcdm_req_i(req), .tcdm_gnt_o(gnt_a),
    .tcdm_add_i(add), .tcdm_wen_i(wen), .tcdm_be_i(be), .tcdm_data_i(wdata),
    .tcdm_r_data_o(rd_a), .tcdm_r_valid_o(rv_a), .cnt_rd_o(crd_a), .cnt_wr_o(cwr_a)
`ifdef TB_TCDM_CONFLICT_CNT_EN
    , .cnt_conflict_o(ccf_a)
`endif
  );

  tb_tcdm_banked_memory #(.NP(NP), .MEMORY_SIZE(MS), .LATENCY(3)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .randomize_i(randomize),
    .stallable_i(stallable), .clear_i(clear), .tcdm_req_i(req), .tcdm_gnt_o(gnt_b),
    .tcdm_add_i(add), .tcdm_wen_i(wen), .tcdm_be_i(be), .tcdm_data_i(wdata),
    .tcdm_r_data_o(rd_b), .tcdm_r_valid_o(rv_b), .cnt_rd_o(crd_b), .cnt_wr_o(cwr_b)
`ifdef TB_TCDM_CONFLICT_CNT_EN
    , .cnt_conflict_o(ccf_b)
`endif
  );

  tb_tcdm_banked_memory #(.NP(NP), .MEMORY_SIZE(MS), .LATENCY(2), .STALL_THRESH(1023)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .randomize_i(randomize),
    .stallable_i(stallable), .clear_i(clear), .tcdm_req_i(req), .tcdm_gnt_o(gnt_c),
    .tcdm_add_i(add), .tcdm_wen_i(wen), .tcdm_be_i(be), .tcdm_data_i(wdata),
    .tcdm_r_data_o(rd_c), .tcdm_r_valid_o(rv_c), .cnt_rd_o(crd_c), .cnt_wr_o(cwr_c)
`ifdef TB_TCDM_CONFLICT_CNT_EN
    , .cnt_conflict_o(ccf_c)
`endif
  );

  typedef struct {
    logic        en;
    logic        wen;
    logic [31:0] add;
    logic [3:0]  be;
    logic [31:0] data;
    logic        exp_gnt;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [16];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
    else n_pass++;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic r, input logic [31:0] a, input logic w,
                          input logic [3:0] b, input logic [31:0] d);
    req[p]          = r;
    add[p*32 +: 32] = a;
    wen[p]          = w;
    be[p*4 +: 4]    = b;
    wdata[p*32 +: 32] = d;
  endtask

  initial begin
    int exp_wr, exp_rdc, gcount;
    logic [31:0] exp_lat [3];

    // en, wen, add, be, data, exp_gnt, exp_rd (response seen the cycle after)
    vecs[0]  = '{1'b1, 1'b0, 32'h10,   4'hF, 32'h1234_5678, 1'b1, 32'h0};
    vecs[1]  = '{1'b1, 1'b1, 32'h10,   4'hF, 32'h0,         1'b1, 32'h1234_5678};
    vecs[2]  = '{1'b1, 1'b0, 32'h0,    4'hF, 32'h0,         1'b1, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 32'h0,    4'h5, 32'hAABB_CCDD, 1'b1, 32'h0};
    vecs[4]  = '{1'b1, 1'b1, 32'h0,    4'hF, 32'h0,         1'b1, 32'h00BB_00DD};
    vecs[5]  = '{1'b0, 1'b1, 32'h0,    4'hF, 32'h0,         1'b0, 32'h00BB_00DD};
    vecs[6]  = '{1'b1, 1'b0, 32'h4,    4'hF, 32'h1111_1111, 1'b1, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 32'h8,    4'hF, 32'h2222_2222, 1'b1, 32'h0};
    vecs[8]  = '{1'b1, 1'b1, 32'h4,    4'hF, 32'h0,         1'b1, 32'h1111_1111};
    vecs[9]  = '{1'b1, 1'b1, 32'h1000, 4'hF, 32'h0,         1'b1, 32'hDEAD_BEEF};
    vecs[10] = '{1'b1, 1'b0, 32'h1000, 4'hF, 32'h5555_5555, 1'b1, 32'h0};
    vecs[11] = '{1'b1, 1'b1, 32'h1000, 4'hF, 32'h0,         1'b1, 32'hDEAD_BEEF};
    vecs[12] = '{1'b1, 1'b1, 32'h13,   4'hF, 32'h0,         1'b1, 32'h1234_5678};
    vecs[13] = '{1'b1, 1'b0, 32'h10,   4'h8, 32'hFF00_0000, 1'b1, 32'h0};
    vecs[14] = '{1'b1, 1'b1, 32'h10,   4'hF, 32'h0,         1'b1, 32'hFF34_5678};
    vecs[15] = '{1'b1, 1'b1, 32'h0,    4'hF, 32'h0,         1'b1, 32'h00BB_00DD};

    rst_n = 1'b0; enable = 1'b1; randomize = 1'b0; stallable = 1'b0; clear = 1'b0;
    req = '0; wen = '0; add = '0; wdata = '0; be = '0;
    set_port(0, 1'b1, 32'h0, 1'b1, 4'hF, 32'h0);
    repeat (3) next_cycle();
    chk("reset_gnt", 32'(gnt_a), 32'h0);
    chk("reset_rvalid", 32'(rv_a), 32'h0);
    chk("reset_rdata", rd_a[31:0], 32'h0);
    chk("reset_cnt_rd", crd_a[31:0], 32'h0);
    rst_n = 1'b1;
    req   = '0;
    next_cycle();

    // Round-robin on bank 0 for ports 0..2; port 3 alone on bank 1.
    for (int i = 0; i < 6; i++) begin
      for (int p = 0; p < 3; p++) set_port(p, 1'b1, 32'h0, 1'b1, 4'hF, 32'h0);
      set_port(3, 1'b1, 32'h4, 1'b1, 4'hF, 32'h0);
      #1;
      chk($sformatf("rr_gnt_%0d", i), 32'(gnt_a[3:0]), 32'((4'b0001 << (i % 3)) | 4'b1000));
      next_cycle();
    end
    req = '0;
    chk("rr_cnt_rd0", crd_a[31:0], 32'd2);
    chk("rr_cnt_rd3", crd_a[3*32 +: 32], 32'd6);
`ifdef TB_TCDM_CONFLICT_CNT_EN
    chk("rr_conflict0", ccf_a[31:0], 32'd4);
    chk("rr_conflict3", ccf_a[3*32 +: 32], 32'd0);
`endif

    clear = 1'b1;
    next_cycle();
    clear = 1'b0;
    chk("clear_cnt_rd3", crd_a[3*32 +: 32], 32'd0);
    set_port(0, 1'b1, 32'h0, 1'b1, 4'hF, 32'h0);
    clear = 1'b1;
    next_cycle();
    clear = 1'b0;
    chk("clear_vs_grant", crd_a[31:0], 32'd0);

    exp_wr = 0; exp_rdc = 0;
    for (int i = 0; i < 16; i++) begin
      enable = vecs[i].en;
      set_port(0, 1'b1, vecs[i].add, vecs[i].wen, vecs[i].be, vecs[i].data);
      #1;
      chk($sformatf("vec%0d_gnt", i), 32'(gnt_a[0]), 32'(vecs[i].exp_gnt));
      if (vecs[i].exp_gnt) begin
        if (vecs[i].wen) exp_rdc++;
        else exp_wr++;
      end
      next_cycle();
      chk($sformatf("vec%0d_rvalid", i), 32'(rv_a[0]), 32'(vecs[i].exp_gnt));
      chk($sformatf("vec%0d_rdata", i), rd_a[31:0], vecs[i].exp_rd);
    end
    enable = 1'b1;
    req    = '0;
    chk("vec_cnt_wr0", cwr_a[31:0], 32'(exp_wr));
    chk("vec_cnt_rd0", crd_a[31:0], 32'(exp_rdc));
    repeat (4) next_cycle();

    // LATENCY=3 instance, back-to-back reads on port 4.
    exp_lat[0] = 32'h00BB_00DD; exp_lat[1] = 32'h1111_1111; exp_lat[2] = 32'h2222_2222;
    for (int j = 0; j < 3; j++) begin
      set_port(4, 1'b1, 32'(4 * j), 1'b1, 4'hF, 32'h0);
      #1;
      chk($sformatf("lat_gnt_%0d", j), 32'(gnt_b[4]), 32'h1);
      next_cycle();
      if (j < 2) chk($sformatf("lat_early_rvalid_c%0d", j + 1), 32'(rv_b[4]), 32'h0);
    end
    req = '0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("lat_rvalid_c%0d", k + 3), 32'(rv_b[4]), (k < 3) ? 32'h1 : 32'h0);
      if (k < 3) chk($sformatf("lat_rdata_c%0d", k + 3), rd_b[4*32 +: 32], exp_lat[k]);
      next_cycle();
    end

    // Stall threshold 1023 on u_c: nearly every cycle stalled.
    randomize = 1'b1; stallable = 1'b1;
    set_port(0, 1'b1, 32'h0, 1'b1, 4'hF, 32'h0);
    gcount = 0;
    for (int i = 0; i < 1000; i++) begin
      #1;
      if (gnt_c[0]) gcount++;
      next_cycle();
    end
    chk("stall_rate_below_2pct", 32'(gcount < 20), 32'h1);
    stallable = 1'b0;
    gcount = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (gnt_c[0]) gcount++;
      next_cycle();
    end
    chk("unstallable_grants", 32'(gcount), 32'd20);
    randomize = 1'b0;
    req = '0;
    repeat (3) next_cycle();

    // Reset one cycle after a read grant on the LATENCY=2 instance.
    set_port(0, 1'b1, 32'h4, 1'b1, 4'hF, 32'h0);
    #1;
    chk("rst_mid_gnt", 32'(gnt_c[0]), 32'h1);
    next_cycle();
    req   = '0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rvalid", 32'(rv_c[0]), 32'h0);
    chk("rst_mid_rdata", rd_c[31:0], 32'h0);
    chk("rst_mid_cnt_rd", crd_c[31:0], 32'h0);
    next_cycle();
    chk("rst_mid_rvalid_due", 32'(rv_c[0]), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      chk($sformatf("rst_after_rvalid_%0d", i), 32'(rv_c[0]), 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/tb_tcdm_banked_memory.md
Name: tb_tcdm_banked_memory

Overview:
Parametrised multi-port, multi-bank TCDM memory model for HWPE testbenches. It is the successor to the flat single-array dummy memory.
- Word-interleaved banks with per-bank round-robin arbitration.
- Configurable fixed response latency.
- LFSR-driven pseudo-random grant stalls.
- Per-port read/write transaction counters.
It serves accelerator TCDM ports and the core data port in the bench top level.

Parameters:
NP, 5, number of master ports
NB, 4, number of banks (power of two, >=1)
MEMORY_SIZE, 262144, total bytes (multiple of 4*NB)
BASE_ADDR, 0, byte address of word 0
LATENCY, 1, cycles from grant to r_valid (>=1)
STALL_THRESH, 102, port stalls when its 10-bit LFSR slice < STALL_THRESH (102 ≈ 10%)
LFSR_SEED, 32'hACE1_1234, non-zero LFSR reset value

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active-low
enable_i  in  1  0: no grants issued on any port
randomize_i  in  1  enables random stalls
stallable_i  in  1  random stalls are applied only while 1
clear_i  in  1  synchronous clear of counters
tcdm_req_i  in  NP  request
tcdm_gnt_o  out  NP  grant (combinational from req)
tcdm_add_i  in  NP*32  byte address
tcdm_wen_i  in  NP  1 = read, 0 = write
tcdm_be_i  in  NP*4  byte enables
tcdm_data_i  in  NP*32  write data
tcdm_r_data_o  out  NP*32  read data
tcdm_r_valid_o  out  NP  response valid
cnt_rd_o  out  NP*32  granted reads per port
cnt_wr_o  out  NP*32  granted writes per port

Behaviour:
- Decode: w = (add - BASE_ADDR) >> 2; bank = w % NB; row = w / NB. Address bits [1:0] are ignored.
- Out-of-range address (add < BASE_ADDR or w >= MEMORY_SIZE/4):
  - The request is granted normally.
  - A write is dropped.
  - A read returns 32'hDEAD_BEEF.
  - The request is counted.
- Eligibility: a port is eligible if req=1 and enable_i=1, and it is not stalled. A port is stalled when randomize_i & stallable_i is 1 and slice_p < STALL_THRESH, where slice_p = rotl(lfsr, 3*p)[9:0].
- LFSR: 32-bit Galois, taps 32,22,2,1. It advances every cycle and resets to LFSR_SEED.
- Arbitration, per bank:
  - At most one grant per cycle.
  - Round-robin starting at rr_ptr[bank]; the lowest index at or after the pointer wins, with wrap-around.
  - After a grant, rr_ptr[bank] = winner+1 mod NP. The pointer is unchanged if there was no grant.
  - Ports targeting different banks are granted in the same cycle.
- Write: bytes with be=1 are updated at the clock edge of the grant cycle. be=0 writes nothing but is still counted and still responds.
- Read data: sampled from the array at the grant edge.
- Response timing: r_valid_o[p] is 1 exactly LATENCY cycles after the grant cycle, for one cycle, for reads and writes alike. Write responses carry r_data = 0.
- Pipelining: a port may be granted every cycle, so responses are fully pipelined. Order per port equals grant order.
- r_data_o: holds its last value when r_valid=0.
- Counters:
  - Increment by 1 on a granted read or write, saturating at 32'hFFFF_FFFF.
  - clear_i zeroes them. If clear_i coincides with a grant, the counter becomes 0, and clear wins.
- Reset (asynchronous, any time, including mid-transaction):
  - gnt/r_valid go to 0, r_data to 0.
  - Counters, rr_ptr, and the response pipeline are cleared; in-flight responses are discarded.
  - The LFSR returns to LFSR_SEED.
  - Memory contents are NOT reset (initialised by $readmemh on the memory array, row-major across banks: word w lives at memory[w]).
- Re-requests: a request held while not granted must keep stable address and data. The model does not check this.

Optional Feature:
TB_TCDM_CONFLICT_CNT_EN:
- Defined: adds output cnt_conflict_o (NP*32). Per port, it increments every cycle the port is eligible but loses bank arbitration. Stall cycles are not counted. It saturates, and is cleared by clear_i and reset.
- Undefined: the port and logic are absent. All other behaviour is identical.

Test Plan:
- Single write then read: port 0 writes 32'h1234_5678 to 0x10 with be=4'hF, then reads it back → gnt in the request cycle; read r_valid after 1 cycle (LATENCY=1) with 32'h1234_5678; cnt_wr_o[0]=1, cnt_rd_o[0]=1.
- Byte enables: write 32'hAABB_CCDD with be=4'b0101 over 0 → read returns 32'h00BB_00DD.
- Bank conflict round-robin: ports 0,1,2 request bank 0 continuously for 6 cycles with randomize_i=0 → grant sequence 0,1,2,0,1,2. In parallel, port 3 hits bank 1 and is granted every cycle. With the macro, cnt_conflict_o[0]=4.
- Latency: LATENCY=3, port 4 issues back-to-back reads of 0x0, 0x4, 0x8 → r_valid on cycles 3, 4, 5 after the first grant, with data in order.
- Random stall: STALL_THRESH=1023, randomize_i=stallable_i=1, 1000 cycles of requests → grant rate <2%. With stallable_i=0 → grant every cycle.
- Reset mid-operation and out-of-range:
  - Assert rst_ni=0 one cycle after a read grant with LATENCY=2 → no r_valid appears; counters read 0.
  - Read from address MEMORY_SIZE → 32'hDEAD_BEEF.
